// File: rtl/mult_result_collector.sv
// Result collector for the lane-parallel multiplier array.
// Credit-gated issue, latency-matched tags, show-ahead result FIFO.
module mult_result_collector #(
  parameter int LANES      = 4,
  parameter int DATA_W     = 32,
  parameter int MULT_LAT   = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [LANES*DATA_W-1:0]            s_opa,
  input  logic [LANES*DATA_W-1:0]            s_opb,
  output logic [LANES*DATA_W-1:0]            mult_opa,
  output logic [LANES*DATA_W-1:0]            mult_opb,
  input  logic [LANES*DATA_W-1:0]            mult_out,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [LANES*DATA_W-1:0]            m_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    inflight
);

  localparam int VW = LANES * DATA_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]   credits;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [MULT_LAT:0] tag;
  logic [VW-1:0]   mem [FIFO_DEPTH];
  logic            accept;
  logic            pop;
  logic            wr;

  assign s_ready  = (credits != '0);
  assign m_valid  = (count != '0);
  assign accept   = s_valid & s_ready;
  assign pop      = m_valid & m_ready;
  assign wr       = tag[MULT_LAT];
  assign inflight = CW'(FIFO_DEPTH) - credits;
  // Empty FIFO shows zero so stale entries never leak out
  assign m_data   = m_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= CW'(FIFO_DEPTH);
    end else if (accept && !pop) begin
      credits <= credits - 1'b1;
    end else if (pop && !accept) begin
      credits <= credits + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_opa <= '0;
      mult_opb <= '0;
    end else if (accept) begin
      mult_opa <= s_opa;
      mult_opb <= s_opb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= '0;
    end else begin
      tag <= {tag[MULT_LAT-1:0], accept};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !wr) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= mult_out;
  end

endmodule

// File: tb/tb_mult_result_collector.sv
// Bench for mult_result_collector: array model, queue reference,
// per-cycle compare plus directed scenarios and random traffic.
module tb_mult_result_collector;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int VW    = LANES * DW;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [VW-1:0] s_opa = '0;
  logic [VW-1:0] s_opb = '0;
  logic [VW-1:0] mult_opa;
  logic [VW-1:0] mult_opb;
  logic [VW-1:0] mult_out = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [VW-1:0] m_data;
  logic [3:0]    inflight;

  always #5 clk = ~clk;

  mult_result_collector dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_opa(s_opa), .s_opb(s_opb),
    .mult_opa(mult_opa), .mult_opb(mult_opb),
    .mult_out(mult_out),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .inflight(inflight)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [VW-1:0] act,
                     input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // single-precision multiply for normal operands, truncating
  function automatic logic [31:0] sp_mul(input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] da, db, dr;
    real r;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
    da = {a[31], {3'b0, a[30:23]} + 11'd896, a[22:0], 29'd0};
    db = {b[31], {3'b0, b[30:23]} + 11'd896, b[22:0], 29'd0};
    r  = $bitstoreal(da) * $bitstoreal(db);
    dr = $realtobits(r);
    return {dr[63], 8'(dr[62:52] - 11'd896), dr[51:29]};
  endfunction

  function automatic logic [VW-1:0] mul_vec(input logic [VW-1:0] a,
                                            input logic [VW-1:0] b);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[i*DW +: DW] = sp_mul(a[i*DW +: DW], b[i*DW +: DW]);
    return r;
  endfunction

  function automatic logic [31:0] rand_sp();
    return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
  endfunction

  // three-stage array: operand change to output in 3 cycles
  logic [VW-1:0] p1 = '0;
  logic [VW-1:0] p2 = '0;
  always @(posedge clk) begin
    p1       <= mul_vec(mult_opa, mult_opb);
    p2       <= p1;
    mult_out <= p2;
  end

  typedef struct {
    longint        vis;
    logic [VW-1:0] data;
  } ent_t;

  ent_t   q[$];
  longint cyc = 0;
  bit     acc_last = 0;
  bit     chk_en = 0;

  function automatic bit exp_valid();
    return q.size() > 0 && q[0].vis <= cyc;
  endfunction

  // result visible on m_valid 4 cycles after its accept edge
  always @(posedge clk or negedge rst_n) begin
    bit ev, er, pp, ac;
    if (!rst_n) begin
      q.delete();
      acc_last = 0;
    end else begin
      ev = exp_valid();
      er = q.size() < DEPTH;
      pp = ev && m_ready;
      ac = s_valid && er;
      if (pp) void'(q.pop_front());
      if (ac) q.push_back('{cyc + 5, mul_vec(s_opa, s_opb)});
      acc_last = ac;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("s_ready", VW'(s_ready), VW'(q.size() < DEPTH));
      chk("m_valid", VW'(m_valid), VW'(exp_valid()));
      chk("inflight", VW'(inflight), VW'(q.size()));
      if (exp_valid()) chk("m_data", m_data, q[0].data);
    end
  end

  task automatic new_vec();
    for (int i = 0; i < LANES; i++) begin
      s_opa[i*DW +: DW] = rand_sp();
      s_opb[i*DW +: DW] = rand_sp();
    end
  endtask

  int sent;
  int drops;
  int vcnt;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1;
    chk("t1_s_ready", VW'(s_ready), VW'(1));
    chk("t1_m_valid", VW'(m_valid), VW'(0));
    chk("t1_inflight", VW'(inflight), VW'(0));
    chk("t1_mult_opa", mult_opa, '0);
    chk("t1_m_data", m_data, '0);
    chk("pin_2x3", VW'(sp_mul(32'h40000000, 32'h40400000)),
        VW'(32'h40C00000));
    chk("pin_1p5xm2", VW'(sp_mul(32'h3FC00000, 32'hC0000000)),
        VW'(32'hC0400000));

    // T2 single op
    m_ready = 1'b1;
    new_vec();
    s_opa[31:0] = 32'h40000000;
    s_opb[31:0] = 32'h40400000;
    s_valid = 1'b1;
    @(negedge clk);
    chk("t2_accepted", VW'(acc_last), VW'(1));
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_early_valid", VW'(m_valid), VW'(0));
    @(negedge clk);
    chk("t2_valid", VW'(m_valid), VW'(1));
    chk("t2_lane0", VW'(m_data[31:0]), VW'(32'h40C00000));
    @(negedge clk);
    chk("t2_after", VW'(m_valid), VW'(0));

    // T3 backpressure
    m_ready = 1'b0;
    sent = 0;
    new_vec();
    s_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (acc_last) begin
        sent++;
        if (sent < 12) new_vec(); else s_valid = 1'b0;
      end
    end
    chk("t3_accepted", VW'(sent), VW'(8));
    chk("t3_s_ready", VW'(s_ready), VW'(0));
    m_ready = 1'b1;
    for (int c = 0; c < 40 && sent < 12; c++) begin
      @(negedge clk);
      if (acc_last) begin
        sent++;
        if (sent < 12) new_vec(); else s_valid = 1'b0;
      end
    end
    chk("t3_all_sent", VW'(sent), VW'(12));
    repeat (10) @(negedge clk);
    chk("t3_drained", VW'(inflight), VW'(0));

    // T4 streaming
    m_ready = 1'b1;
    sent = 0;
    drops = 0;
    vcnt = 0;
    new_vec();
    s_valid = 1'b1;
    for (int c = 0; c < 200 && sent < 100; c++) begin
      @(negedge clk);
      if (!s_ready) drops++;
      if (m_valid) vcnt++;
      if (acc_last) begin
        sent++;
        if (sent < 100) new_vec(); else s_valid = 1'b0;
      end
    end
    repeat (5) begin
      @(negedge clk);
      if (m_valid) vcnt++;
    end
    chk("t4_sent", VW'(sent), VW'(100));
    chk("t4_ready_drops", VW'(drops), VW'(0));
    chk("t4_results", VW'(vcnt), VW'(100));

    // T5 full with simultaneous pop and request
    m_ready = 1'b0;
    sent = 0;
    new_vec();
    s_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (acc_last) begin
        sent++;
        if (sent < 8) new_vec(); else s_valid = 1'b0;
      end
    end
    chk("t5_full_inflight", VW'(inflight), VW'(8));
    chk("t5_full_ready", VW'(s_ready), VW'(0));
    new_vec();
    s_valid = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("t5_ready_back", VW'(s_ready), VW'(1));
    chk("t5_no_accept", VW'(acc_last), VW'(0));
    @(negedge clk);
    s_valid = 1'b0;
    chk("t5_accept", VW'(acc_last), VW'(1));
    chk("t5_inflight", VW'(inflight), VW'(8));
    m_ready = 1'b1;
    repeat (15) @(negedge clk);
    chk("t5_drained", VW'(inflight), VW'(0));

    // T6 reset with 2 ops in FIFO and 3 in the delay line
    m_ready = 1'b0;
    new_vec();
    s_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      new_vec();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("t6_pre_inflight", VW'(inflight), VW'(5));
    chk("t6_pre_valid", VW'(m_valid), VW'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", VW'(m_valid), VW'(0));
    chk("t6_rst_inflight", VW'(inflight), VW'(0));
    chk("t6_rst_ready", VW'(s_ready), VW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t6_no_write", VW'(m_valid), VW'(0));
    end

    // random traffic
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!s_valid || acc_last) begin
        s_valid = ($urandom_range(0, 9) < 7);
        new_vec();
      end
      m_ready = ($urandom_range(0, 9) < 6);
    end
    @(negedge clk);
    if (!s_valid || acc_last) s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 30 && s_valid; c++) begin
      @(negedge clk);
      if (acc_last) s_valid = 1'b0;
    end
    s_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("rand_drained", VW'(inflight), VW'(0));
    chk("rand_empty", VW'(m_valid), VW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
